// File: rtl/fetch_mem_unit.sv
// Fetch/memory access unit: serialises instruction fetches and data loads/stores
// onto a single ack-based memory port and owns the PC, IR and data registers.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ir_write,
    input  logic        i_pc_write,
    input  logic        i_adr_src,
    input  logic        i_data_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_pc_next,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_stall,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_old_pc,
    output logic [31:0] o_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        fetch_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] old_pc_q;
    logic [31:0] instr_q;
    logic [31:0] data_q;

    logic        start_fetch;
    logic        start_data;
    logic        acked;

    // Fetch wins over a data access requested in the same IDLE cycle.
    assign start_fetch = (state_q == IDLE) && i_ir_write;
    assign start_data  = (state_q == IDLE) && !i_ir_write && i_adr_src
                         && (i_data_read || i_mem_write);
    assign acked       = (state_q == REQ) && i_mem_ack;

    always_comb begin
        state_d   = state_q;
        o_mem_req = 1'b0;
        o_stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_fetch || start_data) begin
                    state_d = REQ;
                    o_stall = 1'b1;
                end
            end
            REQ: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                if (i_mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            fetch_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= RESET_PC;
            old_pc_q <= RESET_PC;
            instr_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_fetch) begin
                fetch_q <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= pc_q;
                wdata_q <= i_wdata;
            end else if (start_data) begin
                fetch_q <= 1'b0;
                we_q    <= i_mem_write;
                addr_q  <= i_alu_result;
                wdata_q <= i_wdata;
            end else if (state_q == IDLE && i_pc_write) begin
                pc_q <= i_pc_next;
            end
            // PC advance of a fetch is deferred to its ack so it happens once.
            if (acked) begin
                if (fetch_q) begin
                    instr_q  <= i_mem_rdata;
                    old_pc_q <= pc_q;
                    if (i_pc_write) begin
                        pc_q <= i_pc_next;
                    end
                end else if (!we_q) begin
                    data_q <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_we    = o_mem_req && we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_instr     = instr_q;
    assign o_pc        = pc_q;
    assign o_old_pc    = old_pc_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed + randomized bench for fetch_mem_unit against a transaction-level
// model of the PC, instruction and data registers.
module tb_fetch_mem_unit;

    logic        clk;
    logic        rstn;
    logic        ir_write;
    logic        pc_write;
    logic        adr_src;
    logic        data_read;
    logic        mem_write;
    logic [31:0] pc_next;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_old_pc;
    logic [31:0] m_data;

    fetch_mem_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_ir_write   (ir_write),
        .i_pc_write   (pc_write),
        .i_adr_src    (adr_src),
        .i_data_read  (data_read),
        .i_mem_write  (mem_write),
        .i_pc_next    (pc_next),
        .i_alu_result (alu_result),
        .i_wdata      (wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_stall      (stall),
        .o_instr      (instr),
        .o_pc         (pc),
        .o_old_pc     (old_pc),
        .o_data       (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        adr_src   = 1'b0;
        data_read = 1'b0;
        mem_write = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".old_pc"}, old_pc, m_old_pc);
        chk({tag, ".instr"}, instr, m_instr);
        chk({tag, ".data"}, data, m_data);
    endtask

    // One instruction fetch with `waits` cycles before ack.
    task automatic do_fetch(input logic [31:0] rd, input logic pcw,
                            input logic [31:0] pcn, input int waits,
                            input logic with_data);
        @(negedge clk);
        idle_inputs();
        ir_write   = 1'b1;
        pc_write   = pcw;
        pc_next    = pcn;
        adr_src    = with_data;
        data_read  = with_data;
        alu_result = $urandom;
        #1;
        chk("fetch.start.stall", {31'b0, stall}, 32'd1);
        chk("fetch.start.req", {31'b0, mem_req}, 32'd0);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            mem_ack   = (k == waits);
            mem_rdata = (k == waits) ? rd : $urandom;
            #1;
            chk("fetch.req", {31'b0, mem_req}, 32'd1);
            chk("fetch.we", {31'b0, mem_we}, 32'd0);
            chk("fetch.addr", mem_addr, m_pc);
            chk("fetch.stall", {31'b0, stall}, 32'd1);
            chk("fetch.pc_hold", pc, m_pc);
        end
        m_old_pc = m_pc;
        m_instr  = rd;
        if (pcw) m_pc = pcn;
        // Leave requests and ack asserted in DONE: they must be ignored.
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        pc_next   = $urandom;
        pc_write  = 1'b1;
        #1;
        chk("fetch.done.req", {31'b0, mem_req}, 32'd0);
        chk("fetch.done.stall", {31'b0, stall}, 32'd0);
        chk_regs("fetch.done");
        @(negedge clk);
        idle_inputs();
        #1;
        chk("fetch.idle.stall", {31'b0, stall}, 32'd0);
        chk_regs("fetch.idle");
    endtask

    task automatic do_data(input logic store, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int waits);
        @(negedge clk);
        idle_inputs();
        adr_src    = 1'b1;
        data_read  = !store;
        mem_write  = store;
        alu_result = a;
        wdata      = wd;
        #1;
        chk("data.start.stall", {31'b0, stall}, 32'd1);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            alu_result = $urandom;
            wdata      = $urandom;
            mem_ack    = (k == waits);
            mem_rdata  = (k == waits) ? rd : $urandom;
            #1;
            chk("data.req", {31'b0, mem_req}, 32'd1);
            chk("data.we", {31'b0, mem_we}, {31'b0, store});
            chk("data.addr", mem_addr, a);
            if (store) chk("data.wdata", mem_wdata, wd);
            chk("data.stall", {31'b0, stall}, 32'd1);
        end
        if (!store) m_data = rd;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("data.done.req", {31'b0, mem_req}, 32'd0);
        chk("data.done.stall", {31'b0, stall}, 32'd0);
        chk_regs("data.done");
    endtask

    task automatic do_branch(input logic [31:0] pcn);
        @(negedge clk);
        idle_inputs();
        pc_write = 1'b1;
        pc_next  = pcn;
        #1;
        chk("branch.stall", {31'b0, stall}, 32'd0);
        chk("branch.req", {31'b0, mem_req}, 32'd0);
        m_pc = pcn;
        @(negedge clk);
        idle_inputs();
        #1;
        chk_regs("branch");
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        m_pc     = 32'h0;
        m_old_pc = 32'h0;
        m_instr  = 32'h0;
        m_data   = 32'h0;
        #1;
        chk("rst.req", {31'b0, mem_req}, 32'd0);
        chk("rst.we", {31'b0, mem_we}, 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk_regs("rst");
    endtask

    initial begin
        rstn       = 1'b0;
        pc_next    = '0;
        alu_result = '0;
        wdata      = '0;
        mem_rdata  = '0;
        idle_inputs();
        do_reset();

        do_fetch(32'h0050_0093, 1'b1, 32'h4, 0, 1'b0);
        do_fetch($urandom, 1'b1, 32'h8, 3, 1'b0);
        do_data(1'b0, 32'h100, $urandom, 32'hDEAD_BEEF, 0);
        do_data(1'b1, 32'h104, 32'h1234_5678, $urandom, 2);
        do_fetch($urandom, 1'b1, 32'hC, 1, 1'b1);
        do_branch(32'h0000_0040);
        do_fetch($urandom, 1'b0, $urandom, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: do_fetch($urandom, 1'($urandom), $urandom,
                            $urandom_range(0, 3), 1'($urandom));
                1: do_data(1'b0, $urandom, $urandom, $urandom,
                           $urandom_range(0, 3));
                2: do_data(1'b1, $urandom, $urandom, $urandom,
                           $urandom_range(0, 3));
                default: do_branch($urandom);
            endcase
        end

        // Reset while a fetch is waiting, then a stray ack afterwards.
        @(negedge clk);
        idle_inputs();
        ir_write = 1'b1;
        @(negedge clk);
        #1;
        chk("rif.req", {31'b0, mem_req}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        ir_write  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        m_pc      = 32'h0;
        m_old_pc  = 32'h0;
        m_instr   = 32'h0;
        m_data    = 32'h0;
        #1;
        chk("rif.req0", {31'b0, mem_req}, 32'd0);
        chk("rif.stall", {31'b0, stall}, 32'd0);
        chk_regs("rif");
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rif.late.req", {31'b0, mem_req}, 32'd0);
        chk_regs("rif.late");

        do_fetch(32'h0050_0093, 1'b1, 32'h4, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
